// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver types, frame constants and defaults
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic START_BIT          = 1'b0;
  localparam logic STOP_BIT           = 1'b1;
  localparam int   DATA_BITS          = 8;
  localparam int   DEFAULT_FILTER_LEN = 8;
  localparam int   DEFAULT_TIMEOUT    = 100000;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] bits, input logic par);
    return ^{bits, par};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - 2-FF synchroniser plus consecutive-sample glitch filter
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          at_limit;

  assign at_limit = (cnt == CW'(FILTER_LEN - 1));

  // Level flips on the FILTER_LEN-th consecutive differing sample; FILTER_LEN=1 is a plain resync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (at_limit) begin
        level <= sync2;
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 device-to-host frame receiver with hit/error strobes
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic       clock50,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       hit,
  output logic       error,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT);

  logic          clk_level_unused;
  logic          fe;
  logic          dat;
  logic          dat_fall_unused;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [7:0]    data_n;
  logic          hit_n, error_n;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clock50),
    .rst_n (reset_n),
    .raw   (ps2_clk),
    .level (clk_level_unused),
    .fall  (fe)
  );

  ps2_filter #(.FILTER_LEN(1)) u_dat_sync (
    .clk   (clock50),
    .rst_n (reset_n),
    .raw   (ps2_dat),
    .level (dat),
    .fall  (dat_fall_unused)
  );

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
      data    <= 8'h00;
      hit     <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par     <= par_n;
      tcnt    <= tcnt_n;
      data    <= data_n;
      hit     <= hit_n;
      error   <= error_n;
      busy    <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    tcnt_n    = tcnt;
    data_n    = data;
    hit_n     = 1'b0;
    error_n   = 1'b0;
    if (fe) begin
      tcnt_n = '0;
      unique case (state)
        IDLE: begin
          if (dat == START_BIT) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shift_n = {dat, shift[7:1]};
          if (bit_cnt == 3'(DATA_BITS - 1)) state_n = PARITY;
          else bit_cnt_n = bit_cnt + 3'd1;
        end
        PARITY: begin
          par_n   = dat;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (dat == STOP_BIT && odd_parity_ok(shift, par)) begin
            data_n = shift;
            hit_n  = 1'b1;
          end else begin
            error_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      // Abort on the increment that would reach TIMEOUT-1 so the registered error lands TIMEOUT cycles after the last fe.
      if (tcnt == TW'(TIMEOUT - 2)) begin
        state_n = IDLE;
        error_n = 1'b1;
        tcnt_n  = '0;
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
    end else begin
      tcnt_n = '0;
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - randomized self-checking bench for ps2_receiver
`timescale 1ns/1ps
module tb_ps2_receiver;

  localparam int FL = 8;
  localparam int TO = 500;
  localparam int HP = 40;

  logic       clock50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] data;
  logic       hit;
  logic       error;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int   hit_cnt = 0;
  int   err_cnt = 0;
  int   last_hit_cyc = -1;
  int   last_err_cyc = -1;
  int   both_cnt = 0;
  int   long_cnt = 0;
  logic busy_at_hit = 1'b0;
  logic busy_seen = 1'b0;
  logic prev_hit = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] exp_data = 8'h00;

  ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clock50 (clock50),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .data    (data),
    .hit     (hit),
    .error   (error),
    .busy    (busy)
  );

  always #10 clock50 = ~clock50;
  always @(posedge clock50) cyc <= cyc + 1;

  always @(negedge clock50) begin
    if (hit) begin
      hit_cnt++;
      last_hit_cyc = cyc;
      busy_at_hit  = busy;
    end
    if (error) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (hit && error) both_cnt++;
    if ((hit && prev_hit) || (error && prev_err)) long_cnt++;
    if (busy) busy_seen = 1'b1;
    prev_hit = hit;
    prev_err = error;
  end

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: bench did not finish within 90000 cycles");
    $fatal(1);
  end

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic p, input logic s);
    return {s, p, b, 1'b0};
  endfunction

  // Reference rule: stop must be 1 and the ones count over data+parity must be odd.
  function automatic bit frame_good(input logic [7:0] b, input logic p, input logic s);
    return (s == 1'b1) && ((($countones(b) + int'(p)) % 2) == 1);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock50);
  endtask

  task automatic send_bits(input logic [10:0] frame, input int n, input bit glitch, output int last_fall);
    last_fall = -1;
    for (int i = 0; i < n; i++) begin
      ps2_dat = frame[i];
      if (glitch) begin
        wait_cycles(HP / 2);
        ps2_clk = 1'b0;
        wait_cycles(FL - 1);
        ps2_clk = 1'b1;
        wait_cycles(HP - HP / 2 - (FL - 1));
      end else begin
        wait_cycles(HP);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cycles(HP);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cycles(HP);
  endtask

  task automatic test_reset;
    wait_cycles(3);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %b want 0", hit); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_good_frame;
    int h0, e0, lf;
    h0 = hit_cnt; e0 = err_cnt; busy_seen = 1'b0;
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0, lf);
    exp_data = 8'h1C;
    checks++; if (hit_cnt - h0 !== 1) begin failures++; $display("FAIL good_hit_count: got %0d want 1", hit_cnt - h0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL good_err_count: got %0d want 0", err_cnt - e0); end
    checks++; if (data !== exp_data) begin failures++; $display("FAIL good_data: got %h want %h", data, exp_data); end
    checks++; if (last_hit_cyc !== lf + 3 + FL) begin failures++; $display("FAIL good_hit_latency: got cycle %0d want %0d", last_hit_cyc, lf + 3 + FL); end
    checks++; if (busy_at_hit !== 1'b0) begin failures++; $display("FAIL good_busy_at_hit: got %b want 0", busy_at_hit); end
    checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL good_busy_during_frame: got %b want 1", busy_seen); end
  endtask

  task automatic test_back_to_back;
    int h0, e0, lf;
    h0 = hit_cnt; e0 = err_cnt;
    send_bits(make_frame(8'hF0, 1'b1, 1'b1), 11, 1'b0, lf);
    checks++; if (data !== 8'hF0) begin failures++; $display("FAIL b2b_first_data: got %h want f0", data); end
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0, lf);
    exp_data = 8'h1C;
    checks++; if (data !== exp_data) begin failures++; $display("FAIL b2b_second_data: got %h want %h", data, exp_data); end
    checks++; if (hit_cnt - h0 !== 2) begin failures++; $display("FAIL b2b_hit_count: got %0d want 2", hit_cnt - h0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL b2b_err_count: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_bad_frames;
    int h0, e0, lf;
    h0 = hit_cnt; e0 = err_cnt;
    send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11, 1'b0, lf);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL parity_err_count: got %0d want 1", err_cnt - e0); end
    checks++; if (last_err_cyc !== lf + 3 + FL) begin failures++; $display("FAIL parity_err_latency: got cycle %0d want %0d", last_err_cyc, lf + 3 + FL); end
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11, 1'b0, lf);
    checks++; if (err_cnt - e0 !== 2) begin failures++; $display("FAIL stop_err_count: got %0d want 2", err_cnt - e0); end
    checks++; if (hit_cnt - h0 !== 0) begin failures++; $display("FAIL bad_hit_count: got %0d want 0", hit_cnt - h0); end
    checks++; if (data !== exp_data) begin failures++; $display("FAIL bad_data_kept: got %h want %h", data, exp_data); end
  endtask

  task automatic test_glitch;
    int h0, e0, lf;
    logic [7:0] b;
    h0 = hit_cnt; e0 = err_cnt; busy_seen = 1'b0;
    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    wait_cycles(30);
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL idle_glitch_busy: got %b want 0", busy_seen); end
    b = 8'($urandom);
    send_bits(make_frame(b, ~^b, 1'b1), 11, 1'b1, lf);
    exp_data = b;
    checks++; if (hit_cnt - h0 !== 1) begin failures++; $display("FAIL glitch_hit_count: got %0d want 1", hit_cnt - h0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_err_count: got %0d want 0", err_cnt - e0); end
    checks++; if (data !== exp_data) begin failures++; $display("FAIL glitch_data: got %h want %h", data, exp_data); end
  endtask

  task automatic test_timeout;
    int h0, e0, lf;
    h0 = hit_cnt; e0 = err_cnt;
    send_bits(make_frame(8'($urandom), 1'b0, 1'b1), 5, 1'b0, lf);
    wait_cycles(TO + 50);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL timeout_err_count: got %0d want 1", err_cnt - e0); end
    checks++; if (last_err_cyc !== lf + 2 + FL + TO) begin failures++; $display("FAIL timeout_latency: got cycle %0d want %0d", last_err_cyc, lf + 2 + FL + TO); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b want 0", busy); end
    checks++; if (hit_cnt - h0 !== 0) begin failures++; $display("FAIL timeout_hit_count: got %0d want 0", hit_cnt - h0); end
    send_bits(make_frame(8'h5A, 1'b1, 1'b1), 11, 1'b0, lf);
    exp_data = 8'h5A;
    checks++; if (hit_cnt - h0 !== 1) begin failures++; $display("FAIL after_timeout_hit: got %0d want 1", hit_cnt - h0); end
    checks++; if (data !== exp_data) begin failures++; $display("FAIL after_timeout_data: got %h want %h", data, exp_data); end
  endtask

  task automatic test_reset_midframe;
    int h0, lf;
    logic [10:0] fr;
    fr = make_frame(8'($urandom), 1'b0, 1'b1);
    send_bits(fr, 5, 1'b0, lf);
    #3;
    reset_n = 1'b0;
    #1;
    exp_data = 8'h00;
    checks++; if (data !== exp_data) begin failures++; $display("FAIL midreset_data: got %h want 00", data); end
    checks++; if ({hit, error, busy} !== 3'b000) begin failures++; $display("FAIL midreset_strobes: got %b want 000", {hit, error, busy}); end
    wait_cycles(3);
    reset_n = 1'b1;
    h0 = hit_cnt;
    send_bits(fr >> 5, 6, 1'b0, lf);
    wait_cycles(TO + 50);
    checks++; if (hit_cnt - h0 !== 0) begin failures++; $display("FAIL midreset_rest_hit: got %0d want 0", hit_cnt - h0); end
    send_bits(make_frame(8'h29, 1'b0, 1'b1), 11, 1'b0, lf);
    exp_data = 8'h29;
    checks++; if (hit_cnt - h0 !== 1) begin failures++; $display("FAIL fresh_hit: got %0d want 1", hit_cnt - h0); end
    checks++; if (data !== exp_data) begin failures++; $display("FAIL fresh_data: got %h want %h", data, exp_data); end
  endtask

  task automatic test_random;
    int h0, e0, lf, mode;
    logic [7:0] b;
    logic p, s;
    bit good;
    for (int k = 0; k < 8; k++) begin
      h0 = hit_cnt; e0 = err_cnt;
      b = 8'($urandom);
      mode = int'($urandom_range(0, 3));
      p = ~^b;
      s = 1'b1;
      if (mode == 2) p = ~p;
      if (mode == 3) s = 1'b0;
      good = frame_good(b, p, s);
      send_bits(make_frame(b, p, s), 11, 1'b0, lf);
      if (good) exp_data = b;
      checks++; if (hit_cnt - h0 !== int'(good)) begin failures++; $display("FAIL rand%0d_hit: byte %h got %0d want %0d", k, b, hit_cnt - h0, int'(good)); end
      checks++; if (err_cnt - e0 !== int'(!good)) begin failures++; $display("FAIL rand%0d_err: byte %h got %0d want %0d", k, b, err_cnt - e0, int'(!good)); end
      checks++; if (data !== exp_data) begin failures++; $display("FAIL rand%0d_data: got %h want %h", k, data, exp_data); end
    end
  endtask

  task automatic test_strobe_shape;
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL hit_and_error_together: got %0d want 0", both_cnt); end
    checks++; if (long_cnt !== 0) begin failures++; $display("FAIL strobe_longer_than_one: got %0d want 0", long_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_bad_frames();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    test_random();
    test_strobe_shape();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
PS/2 keyboard serial receiver, upstream of the memory/port controller. It deserialises device-to-host frames from the PS/2 clock and data lines into bytes, and presents each good byte on data with a one-cycle hit strobe. Those two outputs drive the controller's ps2_data/ps2_hit inputs, which the controller samples on the same 50 MHz clock.

Parameters:
FILTER_LEN, 8, consecutive equal samples required before the filtered PS/2 clock changes level (min 2)
TIMEOUT, 100000, clock50 cycles allowed between falling edges inside a frame before abort (2 ms at 50 MHz)

Ports:
clock50  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock line, asynchronous
ps2_dat  input  1  raw PS/2 data line, asynchronous
data     output 8  last correctly received byte (scan code)
hit      output 1  one-cycle strobe: data just updated
error    output 1  one-cycle strobe: frame rejected (parity, stop or timeout)
busy     output 1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, reset_n=0): data=8'h00, hit=0, error=0, busy=0, state=IDLE, bit counter=0, timeout counter=0. Filtered clock is forced to 1 and the synchronisers to 1 (idle bus level).
- Input conditioning: ps2_clk and ps2_dat each pass through 2-FF synchronisers. The synced clock feeds a filter: a counter of consecutive samples differing from the current filtered level; when it reaches FILTER_LEN-1 the filtered level flips and the counter clears. Any matching sample clears the counter. Pulses shorter than FILTER_LEN cycles are ignored.
- Falling edge event fe: filtered clock was 1 and becomes 0 this cycle. At fe, synced ps2_dat is sampled.
- FSM, advancing only on fe:
  IDLE: sample=0 -> DATA with bit count 0. sample=1 -> stay IDLE, no error (spurious start).
  DATA: shift sample in LSB first; after the 8th bit -> PARITY.
  PARITY: store the sample as the parity bit -> STOP.
  STOP: good when stop sample=1 and (XOR of 8 data bits XOR parity)=1, i.e. odd parity. Good -> data<=byte, hit=1 next cycle. Bad -> error=1 next cycle, data unchanged. Both cases -> IDLE.
- Latency: hit/error are high exactly in the cycle after the fe that samples the stop bit, for one cycle only. They are never both high.
- Timeout: in any state other than IDLE the counter increments each cycle and clears on every fe. When it reaches TIMEOUT-1: state->IDLE, error pulses one cycle, partial byte discarded. The counter is held at 0 in IDLE.
- The timeout and an fe in the same cycle: fe wins, counter clears, no error.
- Counter widths: bit counter 3 bits plus state; timeout counter is clog2(TIMEOUT) bits, with no wrap because it saturates through the abort.
- Back-to-back frames: a new start bit is accepted on the first fe after the STOP fe. No dead time is required.
- Host-to-device transmission (inhibit/request-to-send) is not supported. A held-low ps2_clk mid-frame ends in timeout.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Shared package ps2_pkg: state enum (IDLE, DATA, PARITY, STOP), frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8), default FILTER_LEN and TIMEOUT.
- One sub-module, ps2_filter: 2-FF sync plus glitch filter, outputs the filtered level and a fall strobe. Instantiated for ps2_clk. ps2_dat uses only the synchroniser path (FILTER_LEN=1 bypass).

Test Plan:
- Good frame, 10 kHz PS/2 clock, byte 8'h1C (three ones, parity=0, stop=1) -> hit high for one cycle after the stop fe; data=8'h1C; error stays 0; busy falls with hit.
- Byte 8'hF0 (four ones, parity=1) followed immediately by 8'h1C with no idle gap -> two hit pulses; data=8'hF0 then 8'h1C; no error.
- Byte 8'h1C sent with parity=1 -> error pulses once, hit stays 0, data keeps its previous value. Repeat with stop=0 -> same response.
- 3-cycle low glitch on ps2_clk while idle, plus FILTER_LEN-1 glitches between real edges mid-frame -> no state change from the glitches; the frame still decodes correctly.
- Frame stopped after 4 data bits, lines left high -> error asserted exactly TIMEOUT cycles after the last fe; busy=0; the next full frame 8'h5A decodes with hit and data=8'h5A.
- reset_n pulsed low mid-frame after 5 bits -> all outputs 0 immediately (asynchronous); the remaining bits produce no hit. Once reset_n is high, a fresh frame 8'h29 decodes correctly.
